// File: rtl/mp_arith_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
// One word_t is the slice width handled by the adder in a single cycle.
package mp_arith_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/adder_16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with a lookahead carry tree
// across the groups, used once per slice by the sequencer.
module adder_16
    import mp_arith_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] s,
    output logic              cout
);

    logic [WORD_W-1:0] gen;
    logic [WORD_W-1:0] prop;
    logic [3:0]        grp_gen;
    logic [3:0]        grp_prop;
    logic [3:0]        grp_cin;
    logic              cc;

    assign gen  = a & b;
    assign prop = a ^ b;

    // Group generate/propagate, then the carry into each group is formed directly
    // from cin so no group waits on the ripple of the one below it.
    always_comb begin
        grp_gen  = '0;
        grp_prop = '0;
        grp_cin  = '0;
        s        = '0;
        cout     = 1'b0;
        cc       = 1'b0;
        for (int i = 0; i < 4; i++) begin
            grp_gen[i] = gen[i*4+3]
                       | (prop[i*4+3] & gen[i*4+2])
                       | (prop[i*4+3] & prop[i*4+2] & gen[i*4+1])
                       | (prop[i*4+3] & prop[i*4+2] & prop[i*4+1] & gen[i*4]);
            grp_prop[i] = &prop[i*4 +: 4];
        end
        grp_cin[0] = cin;
        grp_cin[1] = grp_gen[0] | (grp_prop[0] & cin);
        grp_cin[2] = grp_gen[1] | (grp_prop[1] & grp_gen[0])
                   | (grp_prop[1] & grp_prop[0] & cin);
        grp_cin[3] = grp_gen[2] | (grp_prop[2] & grp_gen[1])
                   | (grp_prop[2] & grp_prop[1] & grp_gen[0])
                   | (grp_prop[2] & grp_prop[1] & grp_prop[0] & cin);
        cout       = grp_gen[3] | (grp_prop[3] & grp_gen[2])
                   | (grp_prop[3] & grp_prop[2] & grp_gen[1])
                   | (grp_prop[3] & grp_prop[2] & grp_prop[1] & grp_gen[0])
                   | (&grp_prop & cin);
        for (int i = 0; i < 4; i++) begin
            cc = grp_cin[i];
            for (int j = 0; j < 4; j++) begin
                s[i*4+j] = prop[i*4+j] ^ cc;
                cc       = gen[i*4+j] | (prop[i*4+j] & cc);
            end
        end
    end

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit slice per cycle, LSW first,
// through a single shared adder_16 with the inter-slice carry held in a register.
module mp_add_seq
    import mp_arith_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    op_sub,
    input  logic [WORD_W*WORDS-1:0] a,
    input  logic [WORD_W*WORDS-1:0] b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_W*WORDS-1:0] result,
    output logic                    carry,
    output logic                    ovf,
    output logic                    zero,
    output logic                    busy
);

    localparam int TOTAL_W = WORD_W * WORDS;
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [TOTAL_W-1:0] a_reg;
    logic [TOTAL_W-1:0] b_reg;
    logic               op_reg;
    logic               carry_reg;
    word_t              slice_a;
    word_t              slice_b;
    word_t              slice_s;
    logic               slice_cout;
    logic [TOTAL_W-1:0] result_next;

    assign slice_a = a_reg[idx*WORD_W +: WORD_W];
    assign slice_b = b_reg[idx*WORD_W +: WORD_W];

    adder_16 u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_reg),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Result as it will look after this cycle's slice lands; the zero flag
    // needs the complete value on the same edge the last slice is written.
    always_comb begin
        result_next = result;
        result_next[idx*WORD_W +: WORD_W] = slice_s;
    end

    // Subtraction is a + ~b + 1: b is inverted at accept time and the +1 enters
    // as the initial carry. All handshake and status outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= 1'b0;
            carry_reg <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg     <= a;
                        b_reg     <= op_sub ? ~b : b;
                        op_reg    <= op_sub;
                        carry_reg <= op_sub;
                        idx       <= '0;
                        state     <= RUN;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    result    <= result_next;
                    carry_reg <= slice_cout;
                    if (idx == LAST_IDX) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        carry     <= slice_cout ^ op_reg;
                        ovf       <= (a_reg[TOTAL_W-1] == b_reg[TOTAL_W-1])
                                  && (slice_s[WORD_W-1] != a_reg[TOTAL_W-1]);
                        zero      <= ~|result_next;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: directed corner cases on a WORDS=4 instance,
// then random add/sub traffic on WORDS=1 and WORDS=4 instances via a scoreboard.
module tb_mp_add_seq;

    typedef struct packed {
        logic [63:0] res;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv1, ir1, op1, ov1, or1, c1, v1, z1, bz1;
    logic [15:0] a1, b1, r1;
    logic        iv4, ir4, op4, ov4, or4, c4, v4, z4, bz4;
    logic [63:0] a4, b4, r4;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    mp_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op_sub(op1),
        .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .result(r1),
        .carry(c1), .ovf(v1), .zero(z1), .busy(bz1)
    );

    mp_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .op_sub(op4),
        .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4), .result(r4),
        .carry(c4), .ovf(v4), .zero(z4), .busy(bz4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    // Reference arithmetic: borrow is a<b unsigned, overflow from operand/result signs.
    function automatic exp_t model(input int k, input logic [63:0] a, input logic [63:0] b,
                                   input logic op);
        logic [64:0] full;
        logic [63:0] mask;
        int          msb;
        exp_t        e;
        mask = (k == 0) ? 64'hFFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        msb  = (k == 0) ? 15 : 63;
        a    = a & mask;
        b    = b & mask;
        full = {1'b0, a} + {1'b0, b};
        if (op) begin
            e.res = (a - b) & mask;
            e.c   = (a < b);
            e.v   = (a[msb] != b[msb]) && (e.res[msb] != a[msb]);
        end else begin
            e.res = full[63:0] & mask;
            e.c   = (k == 0) ? full[16] : full[64];
            e.v   = (a[msb] == b[msb]) && (e.res[msb] != a[msb]);
        end
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    function automatic logic [63:0] randOperand(input int k);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = (k == 0) ? 64'h8000 : 64'h8000_0000_0000_0000;
            3: v = (k == 0) ? 64'h7FFF : 64'h7FFF_FFFF_FFFF_FFFF;
            4: v = 64'd1;
            default: v = {$urandom, $urandom};
        endcase
        return (k == 0) ? (v & 64'hFFFF) : v;
    endfunction

    task automatic driveIn(input int k, input logic vld, input logic [63:0] a, input logic [63:0] b,
                           input logic op);
        if (k == 0) begin
            iv1 = vld; a1 = a[15:0]; b1 = b[15:0]; op1 = op;
        end else begin
            iv4 = vld; a4 = a; b4 = b; op4 = op;
        end
    endtask

    task automatic setOutReady(input int k, input logic rdy);
        if (k == 0) or1 = rdy;
        else or4 = rdy;
    endtask

    task automatic readOut(input int k, output logic rdy, output logic vld, output exp_t o,
                           output logic bsy);
        if (k == 0) begin
            rdy = ir1; vld = ov1; bsy = bz1;
            o.res = {48'd0, r1}; o.c = c1; o.v = v1; o.z = z1;
        end else begin
            rdy = ir4; vld = ov4; bsy = bz4;
            o.res = r4; o.c = c4; o.v = v4; o.z = z4;
        end
    endtask

    task automatic compareHead(input string tag, input exp_t o);
        exp_t e;
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput({tag, "_result"}, o.res, e.res);
        checkOutput({tag, "_carry"}, o.c, e.c);
        checkOutput({tag, "_ovf"}, o.v, e.v);
        checkOutput({tag, "_zero"}, o.z, e.z);
    endtask

    // Presents a request until accepted, pushing its expected result at accept time,
    // then scrambles the operand pins to show the DUT works from its latched copy.
    task automatic applyStimulus(input int k, input logic [63:0] a, input logic [63:0] b,
                                 input logic op);
        int   guard = 0;
        logic rdy, vld, bsy;
        exp_t o;
        @(negedge clk);
        driveIn(k, 1'b1, a, b, op);
        readOut(k, rdy, vld, o, bsy);
        while (!rdy && guard < 200) begin
            @(negedge clk);
            guard++;
            readOut(k, rdy, vld, o, bsy);
        end
        if (!rdy) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            driveIn(k, 1'b0, a, b, op);
            return;
        end
        sb.push_back(model(k, a, b, op));
        @(negedge clk);
        driveIn(k, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    endtask

    task automatic collectResult(input int k, input string tag, output exp_t o);
        int   guard = 0;
        logic rdy, vld, bsy;
        @(negedge clk);
        setOutReady(k, 1'b1);
        readOut(k, rdy, vld, o, bsy);
        while (!vld && guard < 200) begin
            @(negedge clk);
            guard++;
            readOut(k, rdy, vld, o, bsy);
        end
        if (!vld) begin
            checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
            setOutReady(k, 1'b0);
            return;
        end
        compareHead(tag, o);
        @(negedge clk);
        setOutReady(k, 1'b0);
    endtask

    task automatic runRandom(input int k, input int nops);
        int got = 0;
        int guard = 0;
        fork
            begin
                for (int i = 0; i < nops; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    applyStimulus(k, randOperand(k), randOperand(k), 1'($urandom_range(0, 1)));
                end
            end
            begin
                logic rdy, vld, bsy, ordy;
                exp_t o;
                while (got < nops && guard < nops * 30) begin
                    @(negedge clk);
                    guard++;
                    ordy = ($urandom_range(0, 3) != 0);
                    setOutReady(k, ordy);
                    readOut(k, rdy, vld, o, bsy);
                    if (vld && ordy) begin
                        compareHead("rand", o);
                        got++;
                    end
                end
                if (got < nops) checkOutput("rand_timeout", 64'(got), 64'(nops));
                @(negedge clk);
                setOutReady(k, 1'b0);
            end
        join
    endtask

    initial begin
        logic        rdy, vld, bsy;
        exp_t        o, held;
        int          lat, g;
        logic [63:0] c_op, d_op;

        driveIn(0, 1'b0, 64'd0, 64'd0, 1'b0);
        driveIn(1, 1'b0, 64'd0, 64'd0, 1'b0);
        setOutReady(0, 1'b0);
        setOutReady(1, 1'b0);

        repeat (2) @(negedge clk);
        readOut(1, rdy, vld, o, bsy);
        checkOutput("rst_in_ready", rdy, 1);
        checkOutput("rst_out_valid", vld, 0);
        checkOutput("rst_result", o.res, 0);
        checkOutput("rst_flags", {o.c, o.v, o.z}, 0);
        checkOutput("rst_busy", bsy, 0);
        readOut(0, rdy, vld, o, bsy);
        checkOutput("rst_in_ready_w1", rdy, 1);
        rst_n = 1'b1;

        // Carry out of the top word wraps the sum to zero; latency is WORDS+1.
        @(negedge clk);
        driveIn(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        readOut(1, rdy, vld, o, bsy);
        checkOutput("t1_in_ready", rdy, 1);
        sb.push_back(model(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0));
        @(posedge clk);
        lat = 1;
        #1;
        driveIn(1, 1'b0, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
        readOut(1, rdy, vld, o, bsy);
        checkOutput("t1_busy", bsy, 1);
        while (!vld && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
            readOut(1, rdy, vld, o, bsy);
        end
        checkOutput("t1_latency", 64'(lat), 64'd5);
        collectResult(1, "t1", o);
        checkOutput("t1_result_const", o.res, 64'd0);
        checkOutput("t1_cvz_const", {o.c, o.v, o.z}, 3'b101);

        applyStimulus(1, 64'd0, 64'd1, 1'b1);
        collectResult(1, "t2", o);
        checkOutput("t2_result_const", o.res, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t2_cvz_const", {o.c, o.v, o.z}, 3'b100);

        applyStimulus(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collectResult(1, "t3a", o);
        checkOutput("t3a_result_const", o.res, 64'h8000_0000_0000_0000);
        checkOutput("t3a_cv_const", {o.c, o.v}, 2'b01);
        applyStimulus(1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        collectResult(1, "t3b", o);
        checkOutput("t3b_ovf_const", o.v, 1);

        // Consumer stalls in DONE while a new request waits at the input.
        applyStimulus(1, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0);
        g = 0;
        readOut(1, rdy, vld, held, bsy);
        while (!vld && g < 50) begin
            @(negedge clk);
            g++;
            readOut(1, rdy, vld, held, bsy);
        end
        checkOutput("t4_reached_done", vld, 1);
        c_op = 64'hDEAD_BEEF_0000_0001;
        d_op = 64'h0000_0000_0000_0002;
        driveIn(1, 1'b1, c_op, d_op, 1'b1);
        for (int i = 0; i < 6; i++) begin
            readOut(1, rdy, vld, o, bsy);
            checkOutput("t4_hold_result", o.res, held.res);
            checkOutput("t4_hold_flags", {o.c, o.v, o.z}, {held.c, held.v, held.z});
            checkOutput("t4_hold_valid_ready", {vld, rdy}, 2'b10);
            @(negedge clk);
        end
        setOutReady(1, 1'b1);
        @(negedge clk);
        setOutReady(1, 1'b0);
        readOut(1, rdy, vld, o, bsy);
        checkOutput("t4_release_valid_ready", {vld, rdy}, 2'b01);
        compareHead("t4a", held);
        sb.push_back(model(1, c_op, d_op, 1'b1));
        @(negedge clk);
        driveIn(1, 1'b0, 64'd0, 64'd0, 1'b0);
        readOut(1, rdy, vld, o, bsy);
        checkOutput("t4_new_accepted", {bsy, rdy}, 2'b10);
        collectResult(1, "t4b", o);

        // Asynchronous reset in the middle of RUN discards the partial result.
        applyStimulus(1, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        readOut(1, rdy, vld, o, bsy);
        checkOutput("t5_rst_result", o.res, 0);
        checkOutput("t5_rst_status", {rdy, vld, bsy, o.c, o.v, o.z}, 6'b100000);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        readOut(1, rdy, vld, o, bsy);
        checkOutput("t5_in_ready_after", rdy, 1);
        applyStimulus(1, 64'd1, 64'd2, 1'b0);
        collectResult(1, "t5", o);
        checkOutput("t5_result_const", o.res, 64'd3);

        runRandom(1, 2000);
        runRandom(0, 2000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
